// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares a single 32-bit memory port between ICache refills, DCache refills
//   and DCache write-backs. Every transaction moves one 128-bit line as four
//   32-bit beats. Requests are only looked at in IDLE, and there they are
//   granted by fixed priority: write-back, then DCache read, then ICache read.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   i_rd_req / i_rd_addr       ICache refill request (level) and address
//   i_ret_valid / i_ret_data   ICache refill done pulse and assembled line
//   d_rd_req / d_rd_addr       DCache refill request (level) and address
//   d_ret_valid / d_ret_data   DCache refill done pulse and assembled line
//   d_wr_req / d_wr_addr /
//   d_wr_data                  DCache write-back request, address and line
//   d_wr_ok                    write-back done pulse
//   mem_req / mem_we /
//   mem_addr / mem_addr_ok     memory address phase and its acceptance
//   mem_wdata                  current write beat
//   mem_data_ok / mem_rdata    beat handshake and read beat
module cache_mem_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_rd_req,
  input  logic [31:0]  i_rd_addr,
  output logic         i_ret_valid,
  output logic [127:0] i_ret_data,
  input  logic         d_rd_req,
  input  logic [31:0]  d_rd_addr,
  output logic         d_ret_valid,
  output logic [127:0] d_ret_data,
  input  logic         d_wr_req,
  input  logic [31:0]  d_wr_addr,
  input  logic [127:0] d_wr_data,
  output logic         d_wr_ok,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  input  logic         mem_addr_ok,
  output logic [31:0]  mem_wdata,
  input  logic         mem_data_ok,
  input  logic [31:0]  mem_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_W, OWN_D, OWN_I} owner_t;

  state_t             state_q, state_d;
  owner_t             owner_q;
  logic [31:0]        addr_q;
  logic [3:0][31:0]   wline_q;
  logic [3:0][31:0]   rline_q;
  logic [1:0]         cnt_q;
  logic [127:0]       i_data_q;
  logic [127:0]       d_data_q;

  // Lines are always fetched whole, so the offset bits of the request
  // addresses never reach the memory port.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{i_rd_addr[3:0], d_rd_addr[3:0], d_wr_addr[3:0]};

  assign i_ret_data = i_data_q;
  assign d_ret_data = d_data_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and memory-port outputs. Everything defaults to zero so the
  // port is quiet in every state except the one that owns a given signal.
  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 32'h0;
    mem_wdata   = 32'h0;
    i_ret_valid = 1'b0;
    d_ret_valid = 1'b0;
    d_wr_ok     = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_wr_req || d_rd_req || i_rd_req) state_d = ADDR;
      end
      ADDR: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        mem_we   = (owner_q == OWN_W);
        if (mem_addr_ok) state_d = DATA;
      end
      DATA: begin
        if (owner_q == OWN_W) mem_wdata = wline_q[cnt_q];
        if (mem_data_ok && cnt_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        i_ret_valid = (owner_q == OWN_I);
        d_ret_valid = (owner_q == OWN_D);
        d_wr_ok     = (owner_q == OWN_W);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: grant latching in IDLE, beat capture in DATA. The final beat
  // is merged straight into the owner's return register so the line is
  // already complete during the DONE pulse and then simply holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
      addr_q   <= 32'h0;
      wline_q  <= '0;
      rline_q  <= '0;
      cnt_q    <= 2'd0;
      i_data_q <= 128'h0;
      d_data_q <= 128'h0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= 2'd0;
          if (d_wr_req) begin
            owner_q <= OWN_W;
            addr_q  <= {d_wr_addr[31:4], 4'h0};
            wline_q <= d_wr_data;
          end else if (d_rd_req) begin
            owner_q <= OWN_D;
            addr_q  <= {d_rd_addr[31:4], 4'h0};
          end else if (i_rd_req) begin
            owner_q <= OWN_I;
            addr_q  <= {i_rd_addr[31:4], 4'h0};
          end
        end
        DATA: begin
          if (mem_data_ok) begin
            cnt_q <= cnt_q + 2'd1;
            if (owner_q != OWN_W) rline_q[cnt_q] <= mem_rdata;
            if (cnt_q == 2'd3) begin
              if (owner_q == OWN_I)
                i_data_q <= {mem_rdata, rline_q[2], rline_q[1], rline_q[0]};
              if (owner_q == OWN_D)
                d_data_q <= {mem_rdata, rline_q[2], rline_q[1], rline_q[0]};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
//   Scoreboard bench. The stimulus process issues requests and pushes the
//   expected event stream (address phases, write beats, done pulses). A
//   negedge process plays the memory and pops/compares every event the DUT
//   presents, so stimulus and checking stay independent.
module tb_cache_mem_arbiter;

  localparam int K_ADDR  = 0;
  localparam int K_WBEAT = 1;
  localparam int K_IRET  = 2;
  localparam int K_DRET  = 3;
  localparam int K_WROK  = 4;

  localparam int OWN_W = 0;
  localparam int OWN_D = 1;
  localparam int OWN_I = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_rd_req = 1'b0;
  logic [31:0]  i_rd_addr = 32'h0;
  logic         i_ret_valid;
  logic [127:0] i_ret_data;
  logic         d_rd_req = 1'b0;
  logic [31:0]  d_rd_addr = 32'h0;
  logic         d_ret_valid;
  logic [127:0] d_ret_data;
  logic         d_wr_req = 1'b0;
  logic [31:0]  d_wr_addr = 32'h0;
  logic [127:0] d_wr_data = 128'h0;
  logic         d_wr_ok;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic         mem_addr_ok = 1'b0;
  logic [31:0]  mem_wdata;
  logic         mem_data_ok = 1'b0;
  logic [31:0]  mem_rdata = 32'h0;

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr),
    .i_ret_valid(i_ret_valid), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_addr(d_rd_addr),
    .d_ret_valid(d_ret_valid), .d_ret_data(d_ret_data),
    .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
    .d_wr_ok(d_wr_ok),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_addr_ok(mem_addr_ok), .mem_wdata(mem_wdata),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           kind;
    bit           has_val;
    logic [127:0] val;
    int           cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd_q[$];

  // Memory model knobs, set by the stimulus process.
  int addr_delay  = 0;
  bit toggle_data = 1'b0;
  bit stray       = 1'b0;

  // Memory model state.
  bit dphase   = 1'b0;
  bit ph_we    = 1'b0;
  bit tog      = 1'b1;
  bit awaiting = 1'b0;
  int beats    = 0;
  int wait_cnt = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic void expectEvent(input int kind, input bit hv, input logic [127:0] v, input int c);
    exp_t e;
    e.kind = kind; e.has_val = hv; e.val = v; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  task automatic popCheck(input int kind, input logic [127:0] v, input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s unexpected: actual=%h required=no event", name, v);
    end else begin
      e = exp_q.pop_front();
      checkOutput({name, "_kind"}, 128'(kind), 128'(e.kind));
      if (e.has_val) checkOutput(name, v, e.val);
      if (e.cyc >= 0) checkOutput({name, "_cycle"}, 128'(cyc), 128'(e.cyc));
    end
  endtask

  // Memory responder and monitor. Outputs are sampled first; then the
  // handshakes for the coming posedge are decided, so every event is
  // checked in the cycle in which it will actually be taken.
  always @(negedge clk) begin
    if (rst) begin
      dphase      = 1'b0;
      awaiting    = 1'b0;
      beats       = 0;
      wait_cnt    = 0;
      rd_q.delete();
      mem_addr_ok = 1'b0;
      mem_data_ok = stray;
      mem_rdata   = $urandom;
    end else begin
      if (i_ret_valid) popCheck(K_IRET, i_ret_data, "i_ret");
      if (d_ret_valid) popCheck(K_DRET, d_ret_data, "d_ret");
      if (d_wr_ok)     popCheck(K_WROK, 128'h0, "d_wr_ok");
      if (!mem_req) checkOutput("mem_we_quiet", 128'(mem_we), 128'h0);
      if (!(dphase && ph_we)) checkOutput("mem_wdata_quiet", 128'(mem_wdata), 128'h0);
      if (awaiting) begin
        checkOutput("mem_req_hold", 128'(mem_req), 128'h1);
        if (!mem_req) awaiting = 1'b0;
      end

      mem_addr_ok = 1'b0;
      mem_data_ok = stray && !dphase;
      mem_rdata   = $urandom;
      if (dphase) begin
        mem_data_ok = toggle_data ? tog : 1'b1;
        tog = ~tog;
        if (mem_data_ok) begin
          if (ph_we) popCheck(K_WBEAT, 128'(mem_wdata), "wbeat");
          else if (rd_q.size() > 0) mem_rdata = rd_q.pop_front();
          beats++;
          if (beats == 4) dphase = 1'b0;
        end
      end else if (mem_req) begin
        if (wait_cnt < addr_delay) begin
          wait_cnt++;
          awaiting = 1'b1;
        end else begin
          mem_addr_ok = 1'b1;
          awaiting    = 1'b0;
          wait_cnt    = 0;
          popCheck(K_ADDR, {95'h0, mem_we, mem_addr}, "addr");
          dphase = 1'b1;
          ph_we  = mem_we;
          beats  = 0;
          tog    = 1'b1;
        end
      end
    end
  end

  // Issues one request and queues everything it should produce. The
  // expected memory address is passed in already line-aligned.
  task automatic applyStimulus(input int who, input logic [31:0] addr, input logic [31:0] exp_addr,
                               input logic [127:0] line, input int c_addr, input int c_ret);
    expectEvent(K_ADDR, 1'b1, {95'h0, (who == OWN_W), exp_addr}, c_addr);
    if (who == OWN_W) begin
      for (int i = 0; i < 4; i++) expectEvent(K_WBEAT, 1'b1, 128'(line[32*i +: 32]), -1);
      expectEvent(K_WROK, 1'b0, 128'h0, c_ret);
      d_wr_addr = addr;
      d_wr_data = line;
      d_wr_req  = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) rd_q.push_back(line[32*i +: 32]);
      expectEvent((who == OWN_D) ? K_DRET : K_IRET, 1'b1, line, c_ret);
      if (who == OWN_D) begin
        d_rd_addr = addr;
        d_rd_req  = 1'b1;
      end else begin
        i_rd_addr = addr;
        i_rd_req  = 1'b1;
      end
    end
  endtask

  // Waits for the owner's done pulse and drops its request during DONE.
  task automatic waitFor(input int who, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      if (who == OWN_W && d_wr_ok)     begin seen = 1'b1; d_wr_req = 1'b0; end
      if (who == OWN_D && d_ret_valid) begin seen = 1'b1; d_rd_req = 1'b0; end
      if (who == OWN_I && i_ret_valid) begin seen = 1'b1; i_rd_req = 1'b0; end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: actual=no pulse required=pulse within 60 cycles", name);
      d_wr_req = 1'b0; d_rd_req = 1'b0; i_rd_req = 1'b0;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctl"},
                {61'h0, i_ret_valid, d_ret_valid, d_wr_ok, mem_req, mem_we, mem_addr, mem_wdata},
                128'h0);
    checkOutput({tag, "_i_ret_data"}, i_ret_data, 128'h0);
    checkOutput({tag, "_d_ret_data"}, d_ret_data, 128'h0);
  endtask

  localparam logic [127:0] LINE_I1 = 128'h34567891_02345678_82023456_78910234;
  localparam logic [127:0] LINE_WB = 128'h56789102_12345678_91023456_78910234;
  localparam logic [127:0] LINE_W2 = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
  localparam logic [127:0] LINE_D2 = 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000;
  localparam logic [127:0] LINE_I2 = 128'h11110003_11110002_11110001_11110000;
  localparam logic [127:0] LINE_BP = 128'hCAFE0004_BEEF0003_F00D0002_0BAD0001;
  localparam logic [127:0] LINE_AB = 128'h99999999_88888888_77777777_66666666;
  localparam logic [127:0] LINE_I3 = 128'h0F0F0F0F_E1E1E1E1_5A5A5A5A_C3C3C3C3;

  initial begin
    int c;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] ICache refill, memory always ready");
    c = cyc;
    applyStimulus(OWN_I, 32'hDEBAD004, 32'hDEBAD000, LINE_I1, c + 1, c + 6);
    waitFor(OWN_I, "i_refill");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("i_ret_data_hold", i_ret_data, LINE_I1);

    $display("[TB] DCache write-back");
    c = cyc;
    applyStimulus(OWN_W, 32'h24687580, 32'h24687580, LINE_WB, c + 1, c + 6);
    waitFor(OWN_W, "write_back");
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] simultaneous requests");
    c = cyc;
    applyStimulus(OWN_W, 32'h10000014, 32'h10000010, LINE_W2, c + 1,  c + 6);
    applyStimulus(OWN_D, 32'h2000002C, 32'h20000020, LINE_D2, c + 8,  c + 13);
    applyStimulus(OWN_I, 32'h30000048, 32'h30000040, LINE_I2, c + 15, c + 20);
    waitFor(OWN_W, "simul_w");
    waitFor(OWN_D, "simul_d");
    waitFor(OWN_I, "simul_i");
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] backpressure on address and data phases");
    addr_delay  = 3;
    toggle_data = 1'b1;
    stray       = 1'b1;
    applyStimulus(OWN_D, 32'h40000074, 32'h40000070, LINE_BP, -1, -1);
    waitFor(OWN_D, "backpressure");
    repeat (2) @(posedge clk);
    #1;
    addr_delay  = 0;
    toggle_data = 1'b0;
    stray       = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset in the middle of a refill");
    c = cyc;
    expectEvent(K_ADDR, 1'b1, {95'h0, 1'b0, 32'h50000000}, c + 1);
    for (int i = 0; i < 4; i++) rd_q.push_back(LINE_AB[32*i +: 32]);
    i_rd_addr = 32'h50000008;
    i_rd_req  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst      = 1'b1;
    stray    = 1'b1;
    i_rd_req = 1'b0;
    @(posedge clk); #1;
    checkAllZero("mid_reset");
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkAllZero("after_reset");
    stray = 1'b0;
    @(posedge clk); #1;

    $display("[TB] ICache refill after reset");
    c = cyc;
    applyStimulus(OWN_I, 32'hDEBAD00C, 32'hDEBAD000, LINE_I3, c + 1, c + 6);
    waitFor(OWN_I, "post_reset_refill");
    repeat (4) @(posedge clk);
    #1;

    checkOutput("scoreboard_empty", 128'(exp_q.size()), 128'h0);
    checkOutput("read_beats_consumed", 128'(rd_q.size()), 128'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with the ports named clk and rst as elsewhere in the codebase.
REQ-002 clk  input  1  sole clock; all state updates on posedge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 i_rd_req  input  1  ICache refill request, level, held until i_ret_valid.
REQ-005 i_rd_addr  input  32  ICache refill physical address.
REQ-006 i_ret_valid  output  1  one-cycle pulse; i_ret_data valid.
REQ-007 i_ret_data  output  128  assembled ICache line.
REQ-008 d_rd_req / d_rd_addr  input  1 / 32  DCache refill request (level) and address.
REQ-009 d_ret_valid / d_ret_data  output  1 / 128  DCache refill pulse and line.
REQ-010 d_wr_req / d_wr_addr / d_wr_data  input  1 / 32 / 128  DCache write-back request (level), address and line.
REQ-011 d_wr_ok  output  1  one-cycle pulse; write-back complete.
REQ-012 mem_req / mem_we / mem_addr  output  1 / 1 / 32  memory address phase.
REQ-013 mem_addr_ok  input  1  memory accepted the address phase.
REQ-014 mem_wdata  output  32  current write beat.
REQ-015 mem_data_ok / mem_rdata  input  1 / 32  beat handshake and read beat.

Function
REQ-016 The FSM SHALL have the states IDLE, ADDR, DATA and DONE, plus a latched owner field: W (DCache write), D (DCache read) or I (ICache read).
REQ-017 In IDLE, fixed priority SHALL apply: d_wr_req > d_rd_req > i_rd_req. The grant moves to ADDR on the next edge, latching the owner, the address with bits [3:0] forced to 0, and, for W, d_wr_data.
REQ-018 In ADDR, mem_req=1, mem_addr=latched address and mem_we=(owner==W). The state moves to DATA on the first edge where mem_addr_ok=1; mem_req stays high until then.
REQ-019 In DATA, a 2-bit beat counter SHALL start at 0 and increment on each edge with mem_data_ok=1.
- Read: mem_rdata is stored into line bits [32*cnt+31:32*cnt].
- Write: mem_wdata = latched line word[cnt].
REQ-020 When the beat with cnt==3 is acknowledged, the state SHALL move to DONE. The counter then wraps to 0.
REQ-021 DONE SHALL last exactly one cycle and pulse the owner's output: i_ret_valid, d_ret_valid or d_wr_ok. The state then returns to IDLE.
REQ-022 i_ret_data and d_ret_data SHALL equal the assembled line while their ret_valid is high and SHALL hold that value afterwards.
REQ-023 Requests SHALL NOT be sampled in ADDR, DATA or DONE. A requester that lowers its req during DONE is not re-granted.
REQ-024 Latency with memory always ready: req seen in IDLE at cycle n gives mem_req at n+1, beats at n+2..n+5, and the ret pulse at n+6.
REQ-025 mem_data_ok SHALL be ignored outside DATA, and mem_addr_ok SHALL be ignored outside ADDR.
REQ-026 Outside ADDR, mem_req=0 and mem_we=0. mem_wdata=0 except in DATA with owner W.
REQ-027 Simultaneous requests SHALL be served one after another in priority order, with at least one IDLE cycle between transactions.

Reset
REQ-028 On rst=1 at a posedge, the block SHALL enter IDLE, clear the counter, owner and line buffers, and drive all outputs to 0.
REQ-029 Reset in the middle of a transaction SHALL abandon it with no ret pulse. Later mem_data_ok beats SHALL be ignored.

Verification
REQ-030 I refill: i_rd_req=1, i_rd_addr=DEBAD004; memory acks immediately and returns 78910234, 82023456, 02345678, 34567891.
- Required: mem_addr=DEBAD000 and mem_we=0.
- Required: i_ret_valid pulses once at n+6 with i_ret_data=34567891_02345678_82023456_78910234.
REQ-031 Simultaneous requests: d_wr_req, d_rd_req and i_rd_req all rise in the same cycle.
- Required: order is write-back (mem_we=1), then D read, then I read.
- Required: one d_wr_ok pulse, one d_ret_valid pulse and one i_ret_valid pulse, in that order.
REQ-032 Write-back: d_wr_addr=24687580, d_wr_data=56789102_12345678_91023456_78910234.
- Required: mem_wdata beats are 78910234, 91023456, 12345678, 56789102.
- Required: d_wr_ok pulses after the 4th beat.
REQ-033 Backpressure: mem_addr_ok is held low for 3 cycles and mem_data_ok toggles 1/0.
- Required: mem_req stays high until mem_addr_ok.
- Required: exactly 4 beats are captured and the line is correct.
REQ-034 Reset during DATA after 2 beats.
- Required: no ret pulse; all outputs 0.
- Required: the next I refill returns a correct line at nominal latency.
